// File: rtl/twiddle_pkg.sv
// Shared constants, types and index helper for the 64-point radix-2 twiddle address generator.
package twiddle_pkg;

  localparam int N     = 64;
  localparam int LOG2N = 6;
  localparam int BFLY  = 32;

  localparam logic [2:0]       LAST_STAGE = 3'd5;
  localparam logic [4:0]       LAST_BFLY  = 5'd31;
  // cos(x) = -sin(x + 3pi/2), so the real part reads the same table a quarter turn back.
  localparam logic [LOG2N-1:0] RE_OFFSET  = LOG2N'(N * 3 / 4);

  typedef logic signed [8:0] twiddle_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // k = (b mod 2^s) << (5 - s)
  function automatic logic [LOG2N-1:0] tw_index(input logic [2:0] s, input logic [4:0] b);
    logic [LOG2N-1:0] mask;
    mask = (6'd1 << s) - 6'd1;
    return ({1'b0, b} & mask) << (3'd5 - s);
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Combinational 64-entry twiddle table: T[k] = -sin(2*pi*k/64) in Q1.8, saturated to +/-255.
module twiddle_rom
  import twiddle_pkg::*;
(
  input  logic [LOG2N-1:0] addr,
  output twiddle_t         data
);

  always_comb begin
    // NOTE: assigning a default before the case keeps this purely combinational; no latch can be inferred.
    data = '0;
    case (addr)
      6'd0:  data =  9'sd0;
      6'd1:  data = -9'sd25;
      6'd2:  data = -9'sd50;
      6'd3:  data = -9'sd74;
      6'd4:  data = -9'sd98;
      6'd5:  data = -9'sd121;
      6'd6:  data = -9'sd142;
      6'd7:  data = -9'sd162;
      6'd8:  data = -9'sd181;
      6'd9:  data = -9'sd198;
      6'd10: data = -9'sd213;
      6'd11: data = -9'sd226;
      6'd12: data = -9'sd237;
      6'd13: data = -9'sd245;
      6'd14: data = -9'sd251;
      6'd15: data = -9'sd255;
      6'd16: data = -9'sd255;
      6'd17: data = -9'sd255;
      6'd18: data = -9'sd251;
      6'd19: data = -9'sd245;
      6'd20: data = -9'sd237;
      6'd21: data = -9'sd226;
      6'd22: data = -9'sd213;
      6'd23: data = -9'sd198;
      6'd24: data = -9'sd181;
      6'd25: data = -9'sd162;
      6'd26: data = -9'sd142;
      6'd27: data = -9'sd121;
      6'd28: data = -9'sd98;
      6'd29: data = -9'sd74;
      6'd30: data = -9'sd50;
      6'd31: data = -9'sd25;
      6'd32: data =  9'sd0;
      6'd33: data =  9'sd25;
      6'd34: data =  9'sd50;
      6'd35: data =  9'sd74;
      6'd36: data =  9'sd98;
      6'd37: data =  9'sd121;
      6'd38: data =  9'sd142;
      6'd39: data =  9'sd162;
      6'd40: data =  9'sd181;
      6'd41: data =  9'sd198;
      6'd42: data =  9'sd213;
      6'd43: data =  9'sd226;
      6'd44: data =  9'sd237;
      6'd45: data =  9'sd245;
      6'd46: data =  9'sd251;
      6'd47: data =  9'sd255;
      6'd48: data =  9'sd255;
      6'd49: data =  9'sd255;
      6'd50: data =  9'sd251;
      6'd51: data =  9'sd245;
      6'd52: data =  9'sd237;
      6'd53: data =  9'sd226;
      6'd54: data =  9'sd213;
      6'd55: data =  9'sd198;
      6'd56: data =  9'sd181;
      6'd57: data =  9'sd162;
      6'd58: data =  9'sd142;
      6'd59: data =  9'sd121;
      6'd60: data =  9'sd98;
      6'd61: data =  9'sd74;
      6'd62: data =  9'sd50;
      6'd63: data =  9'sd25;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/twiddle_addr_gen.sv
// Streams the 192 (stage, butterfly, twiddle) tuples of a 64-point radix-2 FFT over a valid/ready link.
// Define TWIDDLE_CONJ_EN to emit conjugated twiddles (tw_im = -T[k]) for the inverse transform.
module twiddle_addr_gen
  import twiddle_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     out_ready,
  output logic                     out_valid,
  output twiddle_t                 tw_re,
  output twiddle_t                 tw_im,
  output logic [2:0]               stage,
  output logic [$clog2(BFLY)-1:0]  bfly,
  output logic                     last,
  output logic                     busy,
  output logic                     done
);

  state_t           state_q, state_nx;
  logic [2:0]       s_q, s_nx;
  logic [4:0]       b_q, b_nx;
  logic             load;
  logic             at_last;
  logic [LOG2N-1:0] k_nx;
  twiddle_t         rom_re, rom_im, im_sel;
  twiddle_t         re_q, im_q;

  assign at_last = (s_q == LAST_STAGE) && (b_q == LAST_BFLY);

  // Next (s, b) is computed here and its twiddle is registered alongside it, so outputs come straight from flops.
  always_comb begin
    state_nx = state_q;
    s_nx     = s_q;
    b_nx     = b_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          s_nx     = 3'd0;
          b_nx     = 5'd0;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (at_last) begin
            state_nx = DONE;
          end else begin
            load = 1'b1;
            if (b_q == LAST_BFLY) begin
              b_nx = 5'd0;
              s_nx = s_q + 3'd1;
            end else begin
              b_nx = b_q + 5'd1;
            end
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign k_nx = tw_index(s_nx, b_nx);

  twiddle_rom u_rom_im (
    .addr (k_nx),
    .data (rom_im)
  );

  twiddle_rom u_rom_re (
    .addr (k_nx + RE_OFFSET),
    .data (rom_re)
  );

`ifdef TWIDDLE_CONJ_EN
  assign im_sel = -rom_im;
`else
  assign im_sel = rom_im;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_nx;
      s_q     <= s_nx;
      b_q     <= b_nx;
      if (load) begin
        re_q <= rom_re;
        im_q <= im_sel;
      end
    end
  end

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign last      = out_valid && at_last;
  assign stage     = s_q;
  assign bfly      = b_q;
  assign tw_re     = re_q;
  assign tw_im     = im_q;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Randomized self-checking bench for twiddle_addr_gen against a trigonometric reference model.
module tb_twiddle_addr_gen;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid, last, busy, done;
  logic signed [8:0] tw_re, tw_im;
  logic [2:0]        stage;
  logic [4:0]        bfly;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef TWIDDLE_CONJ_EN
  localparam int IM_SIGN = -1;
`else
  localparam int IM_SIGN = 1;
`endif

  twiddle_addr_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .stage     (stage),
    .bfly      (bfly),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Q1.8 scale (256) rounded to nearest, saturated to the 9-bit range +/-255.
  function automatic int model_t(input int k);
    real r;
    int  v;
    r = -256.0 * $sin(2.0 * 3.14159265358979 * k / 64.0);
    v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    if (v > 255) v = 255;
    if (v < -255) v = -255;
    return v;
  endfunction

  function automatic int model_k(input int s, input int b);
    return (b % (1 << s)) * (1 << (5 - s));
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_last"}, last, 0);
  endtask

  // mode 0: ready always high; 1: random ready and junk start; 2: ready 1,0,0,1 during stage 2
  task automatic run_frame(input int mode, input int abort_idx);
    int idx, cyc, s, b, k, tog;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    cyc = 1;
    tog = 0;
    while (idx < 192 && cyc < 4000) begin
      s = idx / 32;
      b = idx % 32;
      k = model_k(s, b);
      check("valid", out_valid, 1);
      check("busy", busy, 1);
      check("done_in_run", done, 0);
      check("stage", stage, s);
      check("bfly", bfly, b);
      check("tw_re", tw_re, model_t((k + 48) % 64));
      check("tw_im", tw_im, IM_SIGN * model_t(k));
      check("last", last, (idx == 191) ? 1 : 0);
      if (s == 3 && b == 5) begin
        check("s3b5_im", tw_im, IM_SIGN * -237);
        check("s3b5_re", tw_re, -98);
      end
      if (s == 5 && b == 31) begin
        check("s5b31_im", tw_im, IM_SIGN * -25);
        check("s5b31_re", tw_re, -255);
      end
      if (s == 4 && b == 4) begin
        check("s4b4_im", tw_im, IM_SIGN * -181);
        check("s4b4_re", tw_re, 181);
      end
      if (idx == abort_idx) begin
        rst = 1'b1;
        out_ready = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_quiet("abort");
        check("abort_done", done, 0);
        check("abort_stage", stage, 0);
        check("abort_bfly", bfly, 0);
        check("abort_re", tw_re, 0);
        check("abort_im", tw_im, 0);
        repeat (4) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
          check("abort_idle", out_valid, 0);
        end
        return;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(99) < 60);
        default: begin
          if (s == 2) begin
            out_ready = (tog % 4 == 0) || (tog % 4 == 3);
            tog++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      start = (mode == 1) ? 1'($urandom_range(1)) : 1'b0;
      if (out_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("handshakes", idx, 192);
    if (mode == 0) check("done_latency", cyc, 193);
    check("done_pulse", done, 1);
    check_quiet("done_state");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check_quiet("after_done");
    @(negedge clk);
    check_quiet("start_in_done_ignored");
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", last, 0);
    check("rst_stage", stage, 0);
    check("rst_bfly", bfly, 0);
    check("rst_re", tw_re, 0);
    check("rst_im", tw_im, 0);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_quiet("rst_over_start");
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_quiet("rst_over_start_next");

    run_frame(0, -1);
    run_frame(2, -1);
    run_frame(1, 4 * 32 + 10);
    run_frame(1, -1);
    run_frame(0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
